// File: rtl/rdid_ctrl.sv
// SPI-flash RDID (0x9F) reader: sends the command and captures the 3-byte JEDEC ID.
// Latency 66*CLK_DIV+1 cycles from accepted start to done; start is ignored unless idle.
module rdid_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity,
  output logic       id_valid
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

  localparam logic [7:0] RDID_CMD  = 8'h9F;
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  half_q, half_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [23:0] shreg_q, shreg_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_valid_q, id_valid_d;
  logic [7:0]  mfr_q, mfr_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  cap_q, cap_d;

  logic        half_last;
  logic [4:0]  bit_nxt;
  logic [2:0]  cmd_idx;

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_valid_d = id_valid_q;
    mfr_d      = mfr_q;
    type_d     = type_q;
    cap_d      = cap_q;

    half_last = (half_q == HALF_LAST);
    bit_nxt   = bit_q + 5'd1;
    cmd_idx   = ~bit_nxt[2:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = RDID_CMD[7];
          half_d  = 8'd0;
        end
      end
      CS_SETUP: begin
        if (half_last) begin
          state_d = SHIFT;
          half_d  = 8'd0;
          bit_d   = 5'd0;
          phase_d = 1'b0;
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      SHIFT: begin
        // First cycle of a high phase is the rising edge seen by the flash.
        if (phase_q && (half_q == 8'd0) && (bit_q >= 5'd8)) begin
          shreg_d = {shreg_q[22:0], spi_miso};
        end
        if (half_last) begin
          half_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_q == 5'd31) begin
            state_d = CS_HOLD;
            phase_d = 1'b0;
            bit_d   = 5'd0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            bit_d   = bit_nxt;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = (bit_nxt < 5'd8) ? RDID_CMD[cmd_idx] : 1'b0;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      CS_HOLD: begin
        if (half_last) begin
          state_d    = DONE;
          half_d     = 8'd0;
          cs_n_d     = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          id_valid_d = 1'b1;
          mfr_d      = shreg_q[23:16];
          type_d     = shreg_q[15:8];
          cap_d      = shreg_q[7:0];
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      half_q     <= 8'd0;
      bit_q      <= 5'd0;
      phase_q    <= 1'b0;
      shreg_q    <= 24'd0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_valid_q <= 1'b0;
      mfr_q      <= 8'd0;
      type_q     <= 8'd0;
      cap_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_valid_q <= id_valid_d;
      mfr_q      <= mfr_d;
      type_q     <= type_d;
      cap_q      <= cap_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_sclk        = sclk_q;
  assign spi_mosi        = mosi_q;
  assign id_valid        = id_valid_q;
  assign manufacture_id  = mfr_q;
  assign memory_type     = type_q;
  assign memory_capacity = cap_q;

endmodule

// File: doc/rdid_ctrl.md
RDID_CTRL -- requirements
Module: rdid_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request one RDID transaction; sampled only in IDLE.
REQ-005 busy  output  1  high from the cycle after start is accepted until done pulses.
REQ-006 done  output  1  single-cycle pulse at end of transaction.
REQ-007 spi_cs_n  output  1  flash chip select, active-low.
REQ-008 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 spi_mosi  output  1  serial data to flash.
REQ-010 spi_miso  input  1  serial data from flash.
REQ-011 manufacture_id  output  8  first byte returned by flash.
REQ-012 memory_type  output  8  second byte returned by flash.
REQ-013 memory_capacity  output  8  third byte returned by flash.
REQ-014 id_valid  output  1  high once any transaction has completed since reset.

Function
REQ-015 States SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-016 IDLE -> CS_SETUP on start=1; spi_cs_n SHALL go low and busy high in the cycle after start is sampled.
REQ-017 CS_SETUP SHALL last CLK_DIV cycles with spi_sclk low and spi_mosi = bit 7 of 0x9F.
REQ-018 SHIFT SHALL produce exactly 32 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 spi_mosi SHALL carry 0x9F MSB-first for SCLK periods 1-8, change only when SCLK goes low, and be 0 for periods 9-32.
REQ-020 spi_miso SHALL be sampled on the clk cycle where spi_sclk rises, periods 9-32 only, into a 24-bit shift register, MSB-first.
REQ-021 After the 32nd high phase spi_sclk SHALL return low and CS_HOLD SHALL last CLK_DIV cycles with spi_cs_n still low.
REQ-022 On entry to DONE: spi_cs_n high, done=1, busy=0, id_valid=1, outputs loaded atomically: bits[23:16]->manufacture_id, [15:8]->memory_type, [7:0]->memory_capacity.
REQ-023 The three ID outputs SHALL hold their previous values for the whole transaction; no partial updates.
REQ-024 done SHALL assert exactly 66*CLK_DIV+1 cycles after the cycle start is sampled (265 for CLK_DIV=4).
REQ-025 start while busy, or in the DONE cycle, SHALL be ignored; no queuing.
REQ-026 start held high continuously SHALL begin a new transaction on the first IDLE cycle after DONE.
REQ-027 Bit and half-period counters SHALL wrap only at their terminal counts; there SHALL be no 33rd SCLK edge.

Reset
REQ-028 On rst_n low, immediately and regardless of state: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, id_valid=0, all ID outputs 0x00, counters and shift register 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no done pulse; the first start after rst_n rises SHALL run a full 32-bit transaction.

Verification
REQ-030 Flash model returns 0x20,0xBA,0x19; pulse start -> after 265 cycles done=1 for 1 cycle, ID outputs 0x20/0xBA/0x19, id_valid=1, spi_cs_n high.
REQ-031 Capture spi_mosi on each SCLK rise -> first 8 bits 0x9F, remaining 24 bits 0; exactly 32 SCLK rises per transaction.
REQ-032 start pulses at cycles 10, 50 and 200 after the first start -> only one transaction, one done pulse.
REQ-033 Model returns 0x20,0xBA,0x19, then 0xEF,0x40,0x18 -> outputs stay 0x20/0xBA/0x19 during the second transfer, then switch to 0xEF/0x40/0x18 at its done.
REQ-034 rst_n low at cycle 100 of a transaction -> same cycle spi_cs_n=1, spi_sclk=0, outputs 0x00, id_valid=0, no done; a fresh start then completes normally.
REQ-035 CLK_DIV=2 with model 0x01,0x02,0x03 -> done at cycle 133, outputs 0x01/0x02/0x03.
